audio_tdm_tx: RTL
=================

# audio_tdm_tx

Parametrised multi-channel audio serialiser, the next-generation replacement for the fixed two-channel 8-bit I2S transmitter. It generates its own bit clock from `clk` and accepts whole frames of `NUM_CH` samples over a valid/ready handshake into a one-frame holding buffer. It serialises them in I2S, left-justified or DSP/TDM format with per-slot zero padding. It sits between the sample sources (string synth, PRBS noise) and the audio pins, and reports underruns to the register map.

## Interface
- `AUDIO_DW`, 8: sample width in bits.
- `SLOT_DW`, 16: slot width in bits; must satisfy `SLOT_DW >= AUDIO_DW`.
- `NUM_CH`, 2: channels per frame; must be even in I2S/LJ modes.
- `DIV_W`, 4: width of the clock divider setting.

- `clk`  in  1: system clock; all logic is on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `en`  in  1: transmitter enable.
- `cfg_div`  in  DIV_W: bit clock divider; bit period is 2·(cfg_div+1) clk cycles.
- `cfg_mode`  in  2: frame format. 0 = I2S, 1 = LJ, 2 = DSP, 3 = treated as I2S.
- `frame_data_i`  in  NUM_CH·AUDIO_DW: frame samples; ch k occupies bits [k·AUDIO_DW +: AUDIO_DW].
- `frame_valid_i`  in  1: frame offered.
- `frame_ready_o`  out  1: holding buffer empty.
- `sck_o`  out  1: bit clock.
- `ws_o`  out  1: word select / frame sync.
- `sd_o`  out  1: serial data.
- `underrun_o`  out  1: one-cycle pulse when a frame boundary finds the holding buffer empty.
- `underrun_cnt_o`  out  8: saturating underrun count.

## Operation
- Reset values: sck_o, ws_o, sd_o, underrun_o are 0; underrun_cnt_o is 0; holding buffer is empty; frame_ready_o is 0 while reset is asserted and 1 from the first cycle after it.
- Handshake: a frame is accepted on an edge where frame_valid_i && frame_ready_o. Acceptance sets hold_full, which deasserts ready.
  - ready = ~hold_full, registered.
  - Data is not required to stay stable after acceptance.
- Frame bit position p runs 0..FB-1, where FB = NUM_CH·SLOT_DW, and wraps.
- Slot content: each slot is the sample sent MSB first, followed by SLOT_DW−AUDIO_DW zeros.
- Data delay D: D=1 for I2S and DSP, D=0 for LJ. sd_o at position p carries frame-stream bit (p−D) mod FB.
  - With D=1, p=0 therefore carries the last bit of the previous frame (0 after enable).
- Word select by mode:
  - I2S: ws_o=0 for p<FB/2, else 1.
  - LJ: ws_o=1 for p<FB/2, else 0.
  - DSP: ws_o=1 only at p=0.
- Frame boundary (entry to p=0):
  - cfg_div and cfg_mode are sampled into shadow registers.
  - If hold_full, the holding buffer moves to the shift register and hold_full clears.
  - Otherwise an all-zero frame is sent, underrun_o pulses, and underrun_cnt_o increments, saturating at 255.
- Simultaneous events:
  - An accept on the boundary edge with an empty buffer still underruns; the accepted frame goes to the next frame.
  - An accept and a transfer never coincide, because ready=0 while the buffer is full.
- en=0: the block idles immediately, even mid-frame.
  - sck_o, ws_o and sd_o are driven 0, the divider and p are cleared, and the delay bit is cleared.
  - The holding buffer and the handshake keep working.
- Reset mid-frame: reset returns all state to its reset values on that edge, including emptying the holding buffer.

## Timing
- With en sampled high at edge t while idle:
  - Edge t is the first frame boundary; ws_o and sd_o for p=0 are valid after edge t, and sck_o stays 0.
  - sck_o rises at edge t+(cfg_div+1).
  - sck_o falls at edge t+2(cfg_div+1), on the same edge that p=1 values are driven.
- sd_o and ws_o change only on edges where sck_o falls, so they are stable around the sck_o rising edge where the receiver samples.
- cfg_div=0 gives sck = clk/2.
- Configuration changes take effect only at a frame boundary.
- Latency from accept to the first MSB on sd_o: at most 2·FB bit periods.

## Structure
- Shared package `audio_pkg`:
  - constants MODE_I2S=0, MODE_LJ=1, MODE_DSP=2;
  - function for the frame-bit count FB.
- Sub-module `bclk_gen`: cfg_div counter producing sck_o plus one-cycle `fall_tick` and `rise_tick` strobes; cleared by en=0.
- Top level holds the holding buffer, shift register, p counter, delay flop, ws decode and underrun counter.
- Elaboration check: SLOT_DW ≥ AUDIO_DW, and NUM_CH even.

## Test plan
Unless stated otherwise, AUDIO_DW=8, SLOT_DW=8, NUM_CH=2, cfg_div=0.
- I2S: frame {ch1=A5, ch0=3C}, then en=1.
  - sd_o sampled on sck_o rises reads 0,0,0,1,1,1,1,0,0,1,0,1,0,0,1,0,1.
  - ws_o reads 0×8 then 1×8.
  - sck period is 2 clk.
- LJ, same frame: sd_o reads 3C then A5 with no lead bit; ws_o is 1 for the first 8 bits.
- DSP, NUM_CH=4, SLOT_DW=16, frame 11/22/33/44:
  - ws_o is high for exactly 1 bit of every 64.
  - Each slot is the sample followed by 8 zeros.
- Underrun: no frame supplied for 3 boundaries → all-zero output, three underrun_o pulses, underrun_cnt_o=3. 300 boundaries → 255.
- Back-pressure: hold frame_valid_i high continuously → ready drops after the accept, reasserts on the boundary edge, and exactly one frame is accepted per frame period.
- cfg_div changed 0→3 mid-frame → the bit period stays 2 clk until the boundary, then becomes 8 clk. en dropped mid-frame, or reset, → sck_o, ws_o, sd_o are 0 on the next edge.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the TDM/I2S audio transmitter.
//   MODE_*      : cfg_mode encodings (3 decodes as I2S)
//   frame_bits  : serial bits per frame (channels x slot width)
package audio_pkg;

  localparam logic [1:0] MODE_I2S = 2'd0;
  localparam logic [1:0] MODE_LJ  = 2'd1;
  localparam logic [1:0] MODE_DSP = 2'd2;

  function automatic int unsigned frame_bits(input int unsigned num_ch,
                                             input int unsigned slot_dw);
    return num_ch * slot_dw;
  endfunction

endpackage

// File: rtl/audio_tdm_tx_bclk_gen.sv
// Bit clock generator. Each sck half-period lasts (div+1) clk cycles.
//   clk, rst_n : system clock, synchronous active-low reset
//   run        : counting enable; low clears the counter and forces sck low
//   div        : half-period setting
//   sck        : bit clock
//   fall_tick  : high in the cycle whose closing edge drives sck low
//   rise_tick  : high in the cycle whose closing edge drives sck high
module bclk_gen #(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             sck,
  output logic             fall_tick,
  output logic             rise_tick
);

  logic [DIV_W-1:0] cnt_q;
  logic             sck_q;
  logic             half_done;

  assign half_done = run && (cnt_q == div);
  assign rise_tick = half_done && !sck_q;
  assign fall_tick = half_done && sck_q;
  assign sck       = sck_q;

  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (cnt_q == div) begin
      cnt_q <= '0;
      sck_q <= ~sck_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/audio_tdm_tx.sv
// Multi-channel audio serialiser (I2S / left-justified / DSP-TDM).
//   clk, rst_n      : system clock, synchronous active-low reset
//   en              : transmitter enable; low idles the serial side at once
//   cfg_div         : bit period = 2*(cfg_div+1) clk, sampled per frame
//   cfg_mode        : 0 I2S, 1 LJ, 2 DSP, 3 I2S; sampled per frame
//   frame_data_i    : NUM_CH samples, ch k at [k*AUDIO_DW +: AUDIO_DW]
//   frame_valid_i   : frame offered
//   frame_ready_o   : holding buffer empty
//   sck_o/ws_o/sd_o : bit clock, word select / frame sync, serial data
//   underrun_o      : pulse when a frame boundary finds no frame buffered
//   underrun_cnt_o  : saturating underrun count
module audio_tdm_tx
  import audio_pkg::*;
#(
  parameter int unsigned AUDIO_DW = 8,
  parameter int unsigned SLOT_DW  = 16,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DIV_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [DIV_W-1:0]           cfg_div,
  input  logic [1:0]                 cfg_mode,
  input  logic [NUM_CH*AUDIO_DW-1:0] frame_data_i,
  input  logic                       frame_valid_i,
  output logic                       frame_ready_o,
  output logic                       sck_o,
  output logic                       ws_o,
  output logic                       sd_o,
  output logic                       underrun_o,
  output logic [7:0]                 underrun_cnt_o
);

  localparam int unsigned FB  = frame_bits(NUM_CH, SLOT_DW);
  localparam int unsigned PW  = $clog2(FB);
  localparam int unsigned PAD = SLOT_DW - AUDIO_DW;
  localparam int unsigned FDW = NUM_CH * AUDIO_DW;

  if (SLOT_DW < AUDIO_DW) begin : g_bad_slot
    $error("audio_tdm_tx: SLOT_DW must be >= AUDIO_DW");
  end
  if (NUM_CH % 2 != 0) begin : g_bad_ch
    $error("audio_tdm_tx: NUM_CH must be even");
  end

  // Frame stream, stream bit 0 in the MSB: slot k holds ch k MSB-first then zero padding.
  function automatic logic [FB-1:0] to_stream(input logic [FDW-1:0] d);
    logic [FB-1:0] s;
    s = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      s[FB-1-k*SLOT_DW -: SLOT_DW] = SLOT_DW'(d[k*AUDIO_DW +: AUDIO_DW]) << PAD;
    end
    return s;
  endfunction

  function automatic logic ws_of(input logic [1:0] m, input logic [PW-1:0] p);
    logic w;
    case (m)
      MODE_LJ:  w = (p < PW'(FB / 2));
      MODE_DSP: w = (p == '0);
      default:  w = (p >= PW'(FB / 2));
    endcase
    return w;
  endfunction

  logic [FDW-1:0]   hold_q;
  logic             hold_full_q, hold_full_d;
  logic             ready_q;
  logic [FB-1:0]    shreg_q;
  logic [PW-1:0]    p_q, p_next;
  logic             running_q;
  logic             dly_q;
  logic             ws_q, sd_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       mode_q, mode_now;
  logic             underrun_q;
  logic [7:0]       ucnt_q;

  logic          accept, start, advance, last_pos, boundary, transfer;
  logic [FB-1:0] cur_stream;
  logic          bit_now;
  logic          sd_next;
  logic          fall_tick;
  logic          rise_tick_unused;

  bclk_gen #(
    .DIV_W (DIV_W)
  ) u_bclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (en && running_q),
    .div       (div_q),
    .sck       (sck_o),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick_unused)
  );

  assign accept   = frame_valid_i && ready_q;
  assign last_pos = (p_q == PW'(FB - 1));
  // First boundary is the edge that sees en while idle; sck stays low on that edge.
  assign start    = en && !running_q;
  assign advance  = en && running_q && fall_tick;
  assign boundary = start || (advance && last_pos);
  assign transfer = boundary && hold_full_q;

  always_comb begin
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_full_d = 1'b1;
    end else if (transfer) begin
      hold_full_d = 1'b0;
    end
  end

  always_comb begin
    mode_now   = boundary ? cfg_mode : mode_q;
    p_next     = boundary ? '0 : p_q + PW'(1);
    cur_stream = shreg_q;
    if (boundary) begin
      cur_stream = transfer ? to_stream(hold_q) : '0;
    end
    bit_now = cur_stream[FB-1];
    // LJ sends the current bit; I2S/DSP lag one bit via the delay flop.
    sd_next = (mode_now == MODE_LJ) ? bit_now : dly_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      shreg_q     <= '0;
      p_q         <= '0;
      running_q   <= 1'b0;
      dly_q       <= 1'b0;
      ws_q        <= 1'b0;
      sd_q        <= 1'b0;
      div_q       <= '0;
      mode_q      <= MODE_I2S;
      underrun_q  <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      if (accept) begin
        hold_q <= frame_data_i;
      end
      hold_full_q <= hold_full_d;
      ready_q     <= ~hold_full_d;
      underrun_q  <= 1'b0;

      if (!en) begin
        running_q <= 1'b0;
        p_q       <= '0;
        dly_q     <= 1'b0;
        ws_q      <= 1'b0;
        sd_q      <= 1'b0;
      end else if (boundary || advance) begin
        running_q <= 1'b1;
        p_q       <= p_next;
        shreg_q   <= cur_stream << 1;
        dly_q     <= bit_now;
        sd_q      <= sd_next;
        ws_q      <= ws_of(mode_now, p_next);
        if (boundary) begin
          div_q  <= cfg_div;
          mode_q <= cfg_mode;
          if (!hold_full_q) begin
            underrun_q <= 1'b1;
            if (ucnt_q != 8'hFF) begin
              ucnt_q <= ucnt_q + 8'd1;
            end
          end
        end
      end
    end
  end

  assign frame_ready_o  = ready_q;
  assign ws_o           = ws_q;
  assign sd_o           = sd_q;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = ucnt_q;

endmodule
